// File: rtl/simplez_io_if.sv
// simplez_io_if: CPU-side bus bundle for the Simplez memory-mapped I/O block.
//   addr     - address bus (RA), driven by the CPU
//   lec/esc  - read / write microorders, driven by the CPU
//   data_in  - write data from busD, driven by the CPU
//   data_out - registered read data, driven by the I/O block
//   hit      - registered "data_out is valid for this block", driven by the I/O block
interface simplez_io_if #(
  parameter int DATAW = 12,
  parameter int ADDRW = 9
);
  logic [ADDRW-1:0] addr;
  logic             lec;
  logic             esc;
  logic [DATAW-1:0] data_in;
  logic [DATAW-1:0] data_out;
  logic             hit;

  modport master (output addr, output lec, output esc, output data_in,
                  input data_out, input hit);
  modport slave  (input addr, input lec, input esc, input data_in,
                  output data_out, output hit);
endinterface

// File: rtl/simplez_io.sv
// simplez_io: memory-mapped I/O responder for the Simplez CPU bus.
// Decodes BASE..BASE+3 and serves a screen (8N1 transmitter) and a
// keyboard (8N1 receiver).
//   clk  - system clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - slave side of simplez_io_if (addr, lec, esc, data_in, data_out, hit)
//   tx   - serial out, idle high
//   rx   - serial in, asynchronous (synchronized internally)
module simplez_io #(
  parameter int DATAW    = 12,
  parameter int ADDRW    = 9,
  parameter int BAUD_DIV = 104,
  parameter int BASE     = 508
) (
  input  logic        clk,
  input  logic        rst,
  simplez_io_if.slave bus,
  output logic        tx,
  input  logic        rx
);
  localparam int CNTW = $clog2(BAUD_DIV);
  localparam logic [CNTW-1:0]  CNT_ZERO = CNTW'(0);
  localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(BAUD_DIV - 1);
  localparam logic [CNTW-1:0]  CNT_HALF = CNTW'(BAUD_DIV / 2 - 1);
  localparam logic [ADDRW-3:0] PAGE     = (ADDRW-2)'(BASE >> 2);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  // TX state
  uart_state_e       tx_state_q, tx_state_d;
  logic [CNTW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              tx_q, tx_d;
  // RX state
  logic              rx_meta_q, rx_sync_q;
  uart_state_e       rx_state_q, rx_state_d;
  logic [CNTW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_wait_q, rx_wait_d;
  logic              rx_done_s;
  // Keyboard registers and read path
  logic [7:0]        kbd_data_q, kbd_data_d;
  logic              kbd_ready_q, kbd_ready_d;
  logic              overrun_q, overrun_d;
  logic [DATAW-1:0]  data_out_q, data_out_d, rd_data_s;
  logic              hit_q, hit_d;

  logic              sel_s, rd_s, tx_ready_s, wr_tx_s;
  logic [1:0]        reg_s;
  // Upper write-data bits have no destination in this block.
  logic              unused_s;

  assign unused_s   = ^bus.data_in[DATAW-1:8];
  assign sel_s      = (bus.addr[ADDRW-1:2] == PAGE);
  assign reg_s      = bus.addr[1:0];
  assign rd_s       = bus.lec & sel_s;
  assign tx_ready_s = (tx_state_q == ST_IDLE);
  assign wr_tx_s    = bus.esc & sel_s & (reg_s == 2'd1) & tx_ready_s;

  // TX next-state: one baud period per bit, LSB first; tx_q lags the state by one clk.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = 1'b1;
    case (tx_state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (wr_tx_s) begin
          tx_state_d = ST_START;
          tx_cnt_d   = CNT_ZERO;
          tx_shift_d = bus.data_in[7:0];
        end else begin
          tx_cnt_d = CNT_ZERO;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = CNT_ZERO;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        tx_d = tx_shift_q[0];
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = CNT_ZERO;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = ST_IDLE;
          tx_cnt_d   = CNT_ZERO;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // RX next-state: start bit qualified at half a bit, then mid-bit samples every baud period.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_wait_d  = rx_wait_q;
    rx_done_s  = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = CNT_ZERO;
        if (!rx_sync_q) begin
          rx_state_d = ST_START;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = CNT_ZERO;
          rx_bit_d = 3'd0;
          // Line back high at mid start bit means a glitch, not a frame.
          if (!rx_sync_q) begin
            rx_state_d = ST_DATA;
          end else begin
            rx_state_d = ST_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = CNT_ZERO;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (rx_wait_q) begin
          // Framing error: hold here until the line returns to idle.
          if (rx_sync_q) begin
            rx_state_d = ST_IDLE;
            rx_wait_d  = 1'b0;
          end else begin
            rx_wait_d = 1'b1;
          end
        end else if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = CNT_ZERO;
          if (rx_sync_q) begin
            rx_done_s  = 1'b1;
            rx_state_d = ST_IDLE;
          end else begin
            rx_wait_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        rx_state_d = ST_IDLE;
        rx_wait_d  = 1'b0;
      end
    endcase
  end

  // Keyboard registers: a completing byte takes priority over the clear-on-read.
  always_comb begin
    kbd_data_d  = kbd_data_q;
    kbd_ready_d = kbd_ready_q;
    overrun_d   = overrun_q;
    if (rx_done_s) begin
      kbd_data_d  = rx_shift_q;
      kbd_ready_d = 1'b1;
      overrun_d   = kbd_ready_q;
    end else if (rd_s && (reg_s == 2'd3)) begin
      kbd_ready_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      kbd_ready_d = kbd_ready_q;
    end
  end

  // Read mux: reflects register contents before this edge's updates.
  always_comb begin
    rd_data_s = {DATAW{1'b0}};
    case (reg_s)
      2'd0:    rd_data_s = {{(DATAW-1){1'b0}}, tx_ready_s};
      2'd1:    rd_data_s = {DATAW{1'b0}};
      2'd2:    rd_data_s = {{(DATAW-2){1'b0}}, overrun_q, kbd_ready_q};
      2'd3:    rd_data_s = {{(DATAW-8){1'b0}}, kbd_data_q};
      default: rd_data_s = {DATAW{1'b0}};
    endcase
    hit_d = rd_s;
    if (rd_s) begin
      data_out_d = rd_data_s;
    end else begin
      data_out_d = {DATAW{1'b0}};
    end
  end

  // State registers with synchronous reset; rx synchronizer resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= CNT_ZERO;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'd0;
      tx_q        <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= CNT_ZERO;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      rx_wait_q   <= 1'b0;
      kbd_data_q  <= 8'd0;
      kbd_ready_q <= 1'b0;
      overrun_q   <= 1'b0;
      data_out_q  <= {DATAW{1'b0}};
      hit_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_wait_q   <= rx_wait_d;
      kbd_data_q  <= kbd_data_d;
      kbd_ready_q <= kbd_ready_d;
      overrun_q   <= overrun_d;
      data_out_q  <= data_out_d;
      hit_q       <= hit_d;
    end
  end

  assign tx           = tx_q;
  assign bus.data_out = data_out_q;
  assign bus.hit      = hit_q;
endmodule

// File: tb/tb_simplez_io.sv
// tb_simplez_io: randomized scoreboard bench for simplez_io (BAUD_DIV=4).
// The driver updates a behavioural model and pushes expected read data and
// expected TX frames into queues; independent monitors pop and compare.
module tb_simplez_io;
  localparam int DATAW = 12;
  localparam int ADDRW = 9;
  localparam int B     = 4;
  localparam int BASE  = 508;

  typedef struct {
    logic [7:0] b;
    int         start_cyc;
  } tx_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic rx;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Behavioural model
  int               tx_busy_until = -1;
  logic             m_rdy  = 1'b0;
  logic             m_ovr  = 1'b0;
  logic [7:0]       m_data = 8'd0;
  logic [DATAW-1:0] rd_q[$];
  tx_exp_t          txe_q[$];

  simplez_io_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();

  simplez_io #(.DATAW(DATAW), .ADDRW(ADDRW), .BAUD_DIV(B), .BASE(BASE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .tx (tx),
    .rx (rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle; lec/esc stay asserted until the next driver call clears them.
  task automatic access(input logic do_rd, input logic do_wr,
                        input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d);
    int k;
    logic [DATAW-1:0] e;
    @(negedge clk);
    bus.lec = do_rd; bus.esc = do_wr; bus.addr = a; bus.data_in = d;
    k = cyc + 1;
    if (do_rd && (a >= ADDRW'(BASE))) begin
      case (a - ADDRW'(BASE))
        0:       e = (k > tx_busy_until) ? 12'h001 : 12'h000;
        2:       e = {10'd0, m_ovr, m_rdy};
        3:       e = {4'd0, m_data};
        default: e = 12'h000;
      endcase
      rd_q.push_back(e);
      if (a == ADDRW'(BASE + 3)) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
    end
    if (do_wr && (a == ADDRW'(BASE + 1)) && (k > tx_busy_until)) begin
      txe_q.push_back('{b: d[7:0], start_cyc: k + 1});
      tx_busy_until = k + 10 * B;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.lec = 1'b0; bus.esc = 1'b0;
    end
  endtask

  // Drive one 8N1 frame on rx, then idle line; update the keyboard model.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      repeat (B) begin
        @(negedge clk);
        bus.lec = 1'b0; bus.esc = 1'b0;
        rx = fr[i];
      end
    end
    rx = 1'b1;
    idle(6);
    if (stop_bit) begin
      m_ovr  = m_rdy;
      m_rdy  = 1'b1;
      m_data = b;
    end
  endtask

  task automatic glitch();
    @(negedge clk);
    bus.lec = 1'b0; bus.esc = 1'b0;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    idle(8);
  endtask

  // Read monitor: every hit pops one expected value; no hit means data_out must be 0.
  initial begin : rd_mon
    logic [DATAW-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.hit === 1'b1) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected_hit", 32'd1, 32'd0);
        end else begin
          e = rd_q.pop_front();
          check("rd_data", 32'(bus.data_out), 32'(e));
        end
      end else begin
        check("idle_data_out", 32'(bus.data_out), 32'd0);
      end
    end
  end

  // TX monitor: on a falling edge compare 10*B samples against the expected frame.
  initial begin : tx_mon
    tx_exp_t x;
    logic [9:0] fr;
    @(negedge clk iff rst === 1'b0);
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        if (txe_q.size() == 0) begin
          check("tx_unexpected_frame", 32'd1, 32'd0);
          x = '{b: 8'h00, start_cyc: cyc};
        end else begin
          x = txe_q.pop_front();
        end
        check("tx_start_cycle", 32'(cyc), 32'(x.start_cyc));
        fr = {1'b1, x.b, 1'b0};
        for (int j = 0; j < 10 * B; j++) begin
          if (j > 0) @(negedge clk);
          check("tx_bit", 32'(tx), 32'(fr[j / B]));
        end
      end
    end
  end

  initial begin : main
    int r;
    rst = 1'b1; rx = 1'b1;
    bus.lec = 1'b0; bus.esc = 1'b0; bus.addr = '0; bus.data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_hit", 32'(bus.hit), 32'd0);
    check("reset_data_out", 32'(bus.data_out), 32'd0);
    rst = 1'b0;

    // Reset status reads
    access(1'b1, 1'b0, 9'd508, 12'd0);
    access(1'b1, 1'b0, 9'd510, 12'd0);
    idle(2);

    // TX frame 0xA5, status during frame, ignored write while busy
    access(1'b0, 1'b1, 9'd509, 12'h0A5);
    access(1'b1, 1'b0, 9'd508, 12'd0);
    idle(10);
    access(1'b0, 1'b1, 9'd509, 12'h0FF);
    access(1'b1, 1'b0, 9'd509, 12'd0);
    idle(23);
    access(1'b1, 1'b0, 9'd508, 12'd0);
    access(1'b1, 1'b0, 9'd508, 12'd0);
    access(1'b1, 1'b0, 9'd508, 12'd0);
    // Simultaneous read and write of the data register
    access(1'b1, 1'b1, 9'd509, 12'h13C);
    access(1'b1, 1'b0, 9'd508, 12'd0);
    idle(10 * B + 4);

    // RX single byte
    send_rx(8'h3C, 1'b1);
    access(1'b1, 1'b0, 9'd510, 12'd0);
    access(1'b1, 1'b0, 9'd511, 12'd0);
    access(1'b1, 1'b0, 9'd510, 12'd0);
    idle(1);

    // Overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    access(1'b1, 1'b0, 9'd510, 12'd0);
    access(1'b1, 1'b0, 9'd511, 12'd0);
    access(1'b1, 1'b0, 9'd510, 12'd0);
    idle(1);

    // Decode miss
    access(1'b1, 1'b0, 9'd507, 12'd0);
    @(negedge clk);
    bus.lec = 1'b0;
    check("decode_miss_hit", 32'(bus.hit), 32'd0);
    check("decode_miss_data", 32'(bus.data_out), 32'd0);

    // Framing error and glitch: nothing received
    send_rx(8'h5A, 1'b0);
    access(1'b1, 1'b0, 9'd510, 12'd0);
    glitch();
    access(1'b1, 1'b0, 9'd510, 12'd0);
    access(1'b1, 1'b0, 9'd511, 12'd0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 19);
      if (r < 10) begin
        access(1'b1, 1'b0, 9'(506 + $urandom_range(0, 5)), 12'd0);
      end else if (r < 15) begin
        access(1'($urandom_range(0, 1)), 1'b1, 9'(508 + $urandom_range(0, 3)), 12'($urandom));
      end else if (r < 17) begin
        idle($urandom_range(1, 30));
      end else if (r < 19) begin
        send_rx(8'($urandom), ($urandom_range(0, 3) != 0));
      end else begin
        glitch();
      end
    end
    access(1'b1, 1'b0, 9'd510, 12'd0);
    access(1'b1, 1'b0, 9'd511, 12'd0);
    idle(10 * B + 10);

    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("tx_queue_drained", 32'(txe_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
